// File: rtl/mega_regfile_wb_if.sv
// mega_regfile_wb_if
// Bus between the core/ALU side and the MEGA register file + write-back stage.
//   Write request : stall, wr_en, wr_word, wr_addr, wr_data
//   SREG update   : sreg_we, sreg_alu, sreg_io_we, sreg_io_data
//   Operand reads : rda_addr -> rda_data, rra_addr -> rra_data
//   Status/values : sreg, ptr_x, ptr_y, ptr_z, wb_pending
// master = core side (drives requests), slave = register file.
interface mega_regfile_wb_if;
    logic        stall;
    logic        wr_en;
    logic        wr_word;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        sreg_we;
    logic [7:0]  sreg_alu;
    logic        sreg_io_we;
    logic [7:0]  sreg_io_data;
    logic [4:0]  rda_addr;
    logic [15:0] rda_data;
    logic [4:0]  rra_addr;
    logic [15:0] rra_data;
    logic [7:0]  sreg;
    logic [15:0] ptr_x;
    logic [15:0] ptr_y;
    logic [15:0] ptr_z;
    logic        wb_pending;

    modport master (
        output stall, wr_en, wr_word, wr_addr, wr_data,
        output sreg_we, sreg_alu, sreg_io_we, sreg_io_data,
        output rda_addr, rra_addr,
        input  rda_data, rra_data, sreg, ptr_x, ptr_y, ptr_z, wb_pending
    );

    modport slave (
        input  stall, wr_en, wr_word, wr_addr, wr_data,
        input  sreg_we, sreg_alu, sreg_io_we, sreg_io_data,
        input  rda_addr, rra_addr,
        output rda_data, rra_data, sreg, ptr_x, ptr_y, ptr_z, wb_pending
    );
endinterface

// File: rtl/mega_regfile_wb.sv
// mega_regfile_wb
// 32x8 general register file with a one-entry write-back register and SREG.
// ALU results are captured into the write-back register and committed to the
// array on the following edge; read ports forward the pending bytes so a
// dependent instruction sees the result without stalling.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mega_regfile_wb_if.slave (write request, SREG update, operand
//          reads, pointer pairs X/Y/Z, wb_pending)
module mega_regfile_wb #(
    parameter int unsigned REG_COUNT = 32,
    parameter logic [7:0]  SREG_RST  = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    mega_regfile_wb_if.slave   bus
);

    logic [7:0]  regs_q [REG_COUNT];
    logic        wb_valid_q;
    logic        wb_word_q;
    logic [4:0]  wb_addr_q;
    logic [15:0] wb_data_q;
    logic [7:0]  sreg_q;

    logic        capture;
    logic [4:0]  wb_addr_d;
    logic [7:0]  sreg_d;

    // ------------------------------------------------------------------
    // Capture / SREG next-state
    // ------------------------------------------------------------------
    always_comb begin
        capture   = bus.wr_en & ~bus.stall;
        // Word writes always target an even/odd pair starting on the even reg.
        wb_addr_d = bus.wr_word ? {bus.wr_addr[4:1], 1'b0} : bus.wr_addr;

        sreg_d = sreg_q;
        if (!bus.stall) begin
            if (bus.sreg_io_we)
                sreg_d = bus.sreg_io_data;
            else if (bus.sreg_we)
                sreg_d = bus.sreg_alu;
        end
    end

    // ------------------------------------------------------------------
    // State: array commit, write-back register, SREG
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
            wb_valid_q <= 1'b0;
            wb_word_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            sreg_q     <= SREG_RST;
        end else begin
            // Commit is independent of stall so a pending write never freezes.
            if (wb_valid_q) begin
                regs_q[wb_addr_q] <= wb_data_q[7:0];
                if (wb_word_q)
                    regs_q[{wb_addr_q[4:1], 1'b1}] <= wb_data_q[15:8];
            end

            wb_valid_q <= capture;
            if (capture) begin
                wb_word_q <= bus.wr_word;
                wb_addr_q <= wb_addr_d;
                wb_data_q <= bus.wr_data;
            end

            sreg_q <= sreg_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarded read path
    // ------------------------------------------------------------------
    // One byte of the register file as seen by the next instruction: pending
    // write-back data wins over the array, byte by byte.
    function automatic logic [7:0] rd_byte(input logic [4:0] a);
        logic hit_lo;
        logic hit_hi;
        hit_lo = wb_valid_q && (a == wb_addr_q);
        hit_hi = wb_valid_q && wb_word_q && (a == {wb_addr_q[4:1], 1'b1});
        if (hit_hi)
            return wb_data_q[15:8];
        else if (hit_lo)
            return wb_data_q[7:0];
        else
            return regs_q[a];
    endfunction

    // Word read at r31 has no partner register; the high byte reads zero.
    function automatic logic [15:0] rd_word(input logic [4:0] a);
        logic [7:0] hi;
        hi = (a == 5'd31) ? 8'h00 : rd_byte(a + 5'd1);
        return {hi, rd_byte(a)};
    endfunction

    always_comb begin
        bus.rda_data   = rd_word(bus.rda_addr);
        bus.rra_data   = rd_word(bus.rra_addr);
        bus.ptr_x      = {rd_byte(5'd27), rd_byte(5'd26)};
        bus.ptr_y      = {rd_byte(5'd29), rd_byte(5'd28)};
        bus.ptr_z      = {rd_byte(5'd31), rd_byte(5'd30)};
        bus.sreg       = sreg_q;
        bus.wb_pending = wb_valid_q;
    end

endmodule

// File: tb/tb_mega_regfile_wb.sv
// tb_mega_regfile_wb
// Directed bench for mega_regfile_wb: reset, forwarding, word alignment,
// partial byte forwarding, back-to-back writes, SREG priority and stall.
module tb_mega_regfile_wb;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mega_regfile_wb_if bus ();

    mega_regfile_wb #(
        .REG_COUNT (32),
        .SREG_RST  (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        bus.stall        = 1'b0;
        bus.wr_en        = 1'b0;
        bus.wr_word      = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.sreg_we      = 1'b0;
        bus.sreg_alu     = '0;
        bus.sreg_io_we   = 1'b0;
        bus.sreg_io_data = '0;
    endtask

    task automatic wr(input logic word, input logic [4:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_word = word;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        bus.rda_addr = '0;
        bus.rra_addr = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_pending", {15'd0, bus.wb_pending}, 16'h0000);
        chk("rst_sreg", {8'h00, bus.sreg}, 16'h0000);
        rst_n = 1'b1;

        // Pending write + SREG change, then asynchronous reset mid-cycle
        wr(1'b0, 5'd10, 16'h00FF);
        bus.sreg_we  = 1'b1;
        bus.sreg_alu = 8'h55;
        tick();
        idle();
        bus.rda_addr = 5'd10;
        #1;
        chk("pre_rst_fwd", bus.rda_data, 16'h00FF);
        chk("pre_rst_pending", {15'd0, bus.wb_pending}, 16'h0001);
        chk("pre_rst_sreg", {8'h00, bus.sreg}, 16'h0055);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pending", {15'd0, bus.wb_pending}, 16'h0000);
        chk("async_rst_rda", bus.rda_data, 16'h0000);
        chk("async_rst_rra", bus.rra_data, 16'h0000);
        chk("async_rst_sreg", {8'h00, bus.sreg}, 16'h0000);
        chk("async_rst_ptr_x", bus.ptr_x, 16'h0000);
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.rda_addr = 5'(i);
            #1;
            chk("post_rst_reg", bus.rda_data, 16'h0000);
        end

        // ---------------- dependent forwarding ----------------
        wr(1'b0, 5'd16, 16'h00A5);
        tick();
        idle();
        bus.rda_addr = 5'd16;
        #1;
        chk("fwd_r16", bus.rda_data, 16'h00A5);
        chk("fwd_pending", {15'd0, bus.wb_pending}, 16'h0001);
        tick();
        chk("arr_r16", bus.rda_data, 16'h00A5);
        chk("arr_pending", {15'd0, bus.wb_pending}, 16'h0000);

        // ---------------- word write alignment ----------------
        wr(1'b1, 5'd25, 16'h1234);
        tick();
        idle();
        tick();
        bus.rda_addr = 5'd24;
        #1;
        chk("word_r25_r24", bus.rda_data, 16'h1234);
        chk("word_ptr_x_untouched", bus.ptr_x, 16'h0000);
        wr(1'b1, 5'd27, 16'hBEEF);
        tick();
        idle();
        chk("ptr_x_fwd", bus.ptr_x, 16'hBEEF);
        chk("ptr_x_fwd_pending", {15'd0, bus.wb_pending}, 16'h0001);
        tick();
        chk("ptr_x_arr", bus.ptr_x, 16'hBEEF);
        chk("word_r24_kept", bus.rda_data, 16'h1234);
        chk("ptr_y_zero", bus.ptr_y, 16'h0000);

        // ---------------- partial forward / r31 boundary ----------------
        wr(1'b1, 5'd2, 16'h5566);
        tick();
        wr(1'b0, 5'd31, 16'h004C);
        tick();
        wr(1'b0, 5'd3, 16'h9977);
        tick();
        idle();
        bus.rra_addr = 5'd2;
        #1;
        chk("partial_fwd", bus.rra_data, 16'h7766);
        bus.rra_addr = 5'd31;
        #1;
        chk("r31_no_wrap", bus.rra_data, 16'h004C);
        chk("ptr_z", bus.ptr_z, 16'h4C00);
        bus.rra_addr = 5'd2;
        tick();
        chk("partial_arr", bus.rra_data, 16'h7766);

        // ---------------- back-to-back same register ----------------
        bus.rda_addr = 5'd5;
        wr(1'b0, 5'd5, 16'h0011);
        tick();
        chk("b2b_first", bus.rda_data, 16'h0011);
        wr(1'b0, 5'd5, 16'h0022);
        tick();
        idle();
        chk("b2b_second", bus.rda_data, 16'h0022);
        chk("b2b_pending", {15'd0, bus.wb_pending}, 16'h0001);
        tick();
        chk("b2b_drained", bus.rda_data, 16'h0022);
        chk("b2b_drained_pending", {15'd0, bus.wb_pending}, 16'h0000);

        // ---------------- SREG priority and stall ----------------
        bus.sreg_we      = 1'b1;
        bus.sreg_alu     = 8'h03;
        bus.sreg_io_we   = 1'b1;
        bus.sreg_io_data = 8'h80;
        wr(1'b0, 5'd7, 16'h003C);
        tick();
        chk("sreg_io_priority", {8'h00, bus.sreg}, 16'h0080);
        idle();
        bus.stall    = 1'b1;
        bus.sreg_we  = 1'b1;
        bus.sreg_alu = 8'h02;
        wr(1'b0, 5'd8, 16'h0099);
        tick();
        chk("sreg_stall_hold", {8'h00, bus.sreg}, 16'h0080);
        chk("stall_pending_clear", {15'd0, bus.wb_pending}, 16'h0000);
        bus.rda_addr = 5'd7;
        #1;
        chk("stall_commit_r7", bus.rda_data, 16'h003C);
        idle();
        bus.sreg_we  = 1'b1;
        bus.sreg_alu = 8'h02;
        tick();
        idle();
        chk("sreg_alu_write", {8'h00, bus.sreg}, 16'h0002);
        bus.rda_addr = 5'd8;
        #1;
        chk("stall_dropped_r8", bus.rda_data, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mega_regfile_wb.md
Name: mega_regfile_wb

Overview:
- Register-file and write-back stage around the MEGA/XMEGA ALU.
- Supplies the 16-bit rd/rr operand pairs to the ALU and captures its R result and sreg_out into a one-entry write-back register. Commits that register to the 32x8 general register file and holds SREG.
- Read ports forward pending write-back data byte-wise, so back-to-back dependent ALU instructions need no stall.

Parameters:
- REG_COUNT, 32, number of 8-bit general registers; fixed at 32 for MEGA/XMEGA (5-bit addressing).
- SREG_RST, 8'h00, SREG value after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  core hold; blocks capture of new writes (wr_en, sreg_we, sreg_io_we ignored).
- wr_en  in  1  ALU result write request.
- wr_word  in  1  1 = 16-bit write (MOVW/ADIW/SBIW/MUL family); 0 = byte write of wr_data[7:0].
- wr_addr  in  5  destination register; bit 0 ignored when wr_word=1.
- wr_data  in  16  ALU R output.
- sreg_we  in  1  latch ALU sreg_out.
- sreg_alu  in  8  ALU sreg_out.
- sreg_io_we  in  1  I/O-space write to SREG (OUT/ST to SREG).
- sreg_io_data  in  8  I/O write data.
- rda_addr  in  5  operand A register address.
- rda_data  out  16  {r[rda_addr+1], r[rda_addr]}, forwarded.
- rra_addr  in  5  operand B register address.
- rra_data  out  16  {r[rra_addr+1], r[rra_addr]}, forwarded.
- sreg  out  8  current SREG, fed to ALU sreg_in.
- ptr_x  out  16  {r27,r26}, forwarded.
- ptr_y  out  16  {r29,r28}, forwarded.
- ptr_z  out  16  {r31,r30}, forwarded.
- wb_pending  out  1  write-back register holds uncommitted data.

Behaviour:
- Reset (rst=0, asynchronous): all 32 registers = 8'h00; sreg = SREG_RST; wb_valid = 0. Outputs follow immediately: rda_data, rra_data and all ptr_* = 16'h0000; wb_pending = 0.
- Capture, edge N, with stall=0 and wr_en=1:
  - wb_addr = wr_word ? {wr_addr[4:1],1'b0} : wr_addr.
  - wb_word = wr_word; wb_data = wr_data; wb_valid = 1.
- Commit, edge N+1: if wb_valid, write r[wb_addr] = wb_data[7:0]; if wb_word, also write r[wb_addr+1] = wb_data[15:8].
  - Same edge: wb_valid reloads from a new capture, or clears if there is none.
  - Commit happens regardless of stall; stall never freezes a pending write.
- Back-to-back writes to the same register: the older value commits and the newer value is captured on the same edge. The array then holds the newer value after the following edge.
- Read path is combinational:
  - Byte address b is forwarded from wb_data when wb_valid and b matches a byte covered by the pending write; otherwise it comes from the array.
  - Forwarding is per byte: a word read overlapping one byte of a pending byte write mixes forwarded and array bytes.
- Word reads at address 31: the high byte is 8'h00 (no wrap to r0).
- Result latency: a value written at edge N is visible on read ports from edge N onward via forwarding, and in the array from N+1.
- SREG update on an edge with stall=0:
  - sreg_io_we has priority: sreg = sreg_io_data.
  - Otherwise, if sreg_we: sreg = sreg_alu.
  - Otherwise: hold.
  - SREG has no write-back delay: the next instruction sees the new flags directly from sreg.
- stall=1: no new capture and no SREG change; pending wb still commits, and wb_pending falls after that edge.
- wb_pending = wb_valid.
- Reset mid-operation: a pending write is discarded and never reaches the array.

Test Plan:
- Reset, then read: rst low with wb_valid=1 -> wb_pending=0, rda_data=rra_data=16'h0000, sreg=8'h00 asynchronously. After release, all 32 registers read 0.
- Dependent forwarding: edge 0 write byte r16=8'hA5. Cycle 1: rda_addr=16 returns 16'h00A5 with wb_pending=1. After edge 1, same read returns 16'h00A5 from the array with wb_pending=0.
- Word write alignment: wr_word=1, wr_addr=25, wr_data=16'h1234 -> r24=8'h34, r25=8'h12; ptr_x unchanged. Then wr_addr=27, wr_data=16'hBEEF -> ptr_x=16'hBEEF, forwarded in the cycle after capture.
- Partial forward: r3:r2=16'h5566 in the array; byte write r3=8'h77 pending -> rra_addr=2 gives 16'h7766. rra_addr=31 gives high byte 8'h00.
- Back-to-back same register: writes r5=8'h11 then r5=8'h22 on consecutive edges, with a read of r5 each cycle -> read 8'h11 then 8'h22. After the drain edge the array holds 8'h22.
- SREG priority and stall: sreg_we=1 with sreg_alu=8'h03, and sreg_io_we=1 with sreg_io_data=8'h80, same edge -> sreg=8'h80. Next edge, stall=1 with sreg_we=1 and sreg_alu=8'h02 -> sreg stays 8'h80, and a pending write still commits.
